present_round_ctrl: RTL

Sequencing controller for the PRESENT-80 datapath. It takes a start request and drives the per-cycle strobes that the state register, S-box layer, permutation layer and 80-bit key register need to run a full encryption or decryption. For decryption it first runs a forward key-schedule pre-pass so the datapath holds the last round key. It replaces ad-hoc control inside the datapath top with one registered FSM plus round counter.

---
 rtl/present_pkg.sv | 66 ++++++
 rtl/present_round_ctrl_if.sv | 31 +++
 rtl/present_round_counter.sv | 50 +++++
 rtl/present_round_ctrl.sv | 127 ++++++++++++
 4 files changed

// File: rtl/present_pkg.sv
// Shared constants and strobe decode for the PRESENT-80 round controller.
// The datapath top and the bench import the same encodings.
package present_pkg;

  localparam int NUM_ROUNDS = 31;
  localparam int ROUND_W    = 5;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_KEYGEN = 3'd2;
  localparam logic [2:0] S_WHITEN = 3'd3;
  localparam logic [2:0] S_ROUND  = 3'd4;
  localparam logic [2:0] S_FINAL  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  typedef struct packed {
    logic busy;
    logic done;
    logic init;
    logic load_state;
    logic add_key;
    logic sub_perm;
    logic key_step;
  } strobe_t;

  // Per-state strobe pattern; dir and round_ctr are handled outside.
  function automatic strobe_t strobes_of(input logic [2:0] st);
    strobe_t s;
    s = '0;
    case (st)
      S_LOAD: begin
        s.busy       = 1'b1;
        s.load_state = 1'b1;
      end
      S_KEYGEN: begin
        s.busy     = 1'b1;
        s.init     = 1'b1;
        s.key_step = 1'b1;
      end
      S_WHITEN, S_FINAL: begin
        s.busy       = 1'b1;
        s.init       = 1'b1;
        s.load_state = 1'b1;
        s.add_key    = 1'b1;
      end
      S_ROUND: begin
        s.busy       = 1'b1;
        s.init       = 1'b1;
        s.load_state = 1'b1;
        s.add_key    = 1'b1;
        s.sub_perm   = 1'b1;
        s.key_step   = 1'b1;
      end
      S_DONE: begin
        s.busy = 1'b1;
        s.done = 1'b1;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/present_round_ctrl_if.sv
// Request/strobe bundle between a requester/datapath and the round controller.
interface present_round_ctrl_if;
  import present_pkg::*;

  logic               start;
  logic               mode;
  logic               abort;
  logic               busy;
  logic               done;
  logic               dir;
  logic               init;
  logic               load_state;
  logic               add_key;
  logic               sub_perm;
  logic               key_step;
  logic [ROUND_W-1:0] round_ctr;
  logic [2:0]         fsm_state;

  modport master (
    output start, mode, abort,
    input  busy, done, dir, init, load_state, add_key, sub_perm, key_step,
           round_ctr, fsm_state
  );

  modport slave (
    input  start, mode, abort,
    output busy, done, dir, init, load_state, add_key, sub_perm, key_step,
           round_ctr, fsm_state
  );

endinterface

// File: rtl/present_round_counter.sv
// Saturating up/down round counter with synchronous load and terminal flags.
module present_round_counter
  import present_pkg::*;
#(
  parameter int W   = ROUND_W,
  parameter int MAX = NUM_ROUNDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         up,
  output logic [W-1:0] cnt,
  output logic         at_max,
  output logic         at_one
);

  localparam logic [W-1:0] MAX_V = W'(MAX);
  localparam logic [W-1:0] ONE_V = W'(1);

  logic [W-1:0] cnt_q, cnt_d;

  // Saturate at both ends so the count can never leave 0..MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      if (up && (cnt_q != MAX_V)) begin
        cnt_d = cnt_q + ONE_V;
      end else if (!up && (cnt_q != '0)) begin
        cnt_d = cnt_q - ONE_V;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt    = cnt_q;
  assign at_max = (cnt_q == MAX_V);
  assign at_one = (cnt_q == ONE_V);

endmodule

// File: rtl/present_round_ctrl.sv
// PRESENT-80 sequencing FSM: registered strobes, dir latch and round counter
// for encryption and for decryption with its forward key pre-pass.
module present_round_ctrl #(
  parameter int NUM_ROUNDS = present_pkg::NUM_ROUNDS,
  parameter int ROUND_W    = present_pkg::ROUND_W
) (
  input  logic                 clk,
  input  logic                 rst,
  present_round_ctrl_if.slave  bus
);
  import present_pkg::*;

  logic [2:0]         state_q, state_d;
  logic               dir_q, dir_d;
  strobe_t            out_q, out_d;

  logic               cnt_load;
  logic [ROUND_W-1:0] cnt_val;
  logic               cnt_en;
  logic               cnt_up;
  logic [ROUND_W-1:0] ctr;
  logic               at_max;
  logic               at_one;

  present_round_counter #(
    .W   (ROUND_W),
    .MAX (NUM_ROUNDS)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_en),
    .up       (cnt_up),
    .cnt      (ctr),
    .at_max   (at_max),
    .at_one   (at_one)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      dir_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      out_q   <= out_d;
    end
  end

  // Counter moves on the same edge as the state, so round_ctr always matches
  // the state it is shown with. Abort overrides everything but keeps dir.
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_en   = 1'b0;
    cnt_up   = 1'b1;
    if (bus.abort) begin
      state_d  = S_IDLE;
      cnt_load = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_d  = S_LOAD;
            dir_d    = bus.mode;
            cnt_load = 1'b1;
            cnt_val  = ROUND_W'(1);
          end
        end
        S_LOAD: begin
          state_d = (dir_q == MODE_DEC) ? S_KEYGEN : S_ROUND;
        end
        S_KEYGEN: begin
          if (at_max) state_d = S_WHITEN;
          else        cnt_en  = 1'b1;
        end
        S_WHITEN: begin
          state_d = S_ROUND;
        end
        S_ROUND: begin
          if (dir_q == MODE_ENC) begin
            if (at_max) state_d = S_FINAL;
            else        cnt_en  = 1'b1;
          end else if (at_one) begin
            state_d  = S_DONE;
            cnt_load = 1'b1;
          end else begin
            cnt_en = 1'b1;
            cnt_up = 1'b0;
          end
        end
        S_FINAL: begin
          state_d  = S_DONE;
          cnt_load = 1'b1;
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d  = S_IDLE;
          cnt_load = 1'b1;
        end
      endcase
    end
  end

  // Strobes are decoded from the next state and registered with it.
  always_comb begin
    out_d = strobes_of(state_d);
  end

  assign bus.busy       = out_q.busy;
  assign bus.done       = out_q.done;
  assign bus.init       = out_q.init;
  assign bus.load_state = out_q.load_state;
  assign bus.add_key    = out_q.add_key;
  assign bus.sub_perm   = out_q.sub_perm;
  assign bus.key_step   = out_q.key_step;
  assign bus.dir        = dir_q;
  assign bus.round_ctr  = ctr;
  assign bus.fsm_state  = state_q;

endmodule
